// File: rtl/cam_lut_reg_ctrl.sv
// cam_lut_reg_ctrl: host register front-end that turns single-beat register
// accesses into CAM/LUT table rd_req/rd_ack and wr_req/wr_ack handshakes.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_reg_*, o_reg_*        host register bus (req strobe, rd/wr_L, 3-bit word
//                           offset, write data; one-cycle ack with read data)
//   o_tbl_rd_*, i_tbl_rd_*  table read: address/request out, entry/ack in
//   o_tbl_wr_*, i_tbl_wr_*  table write: address/request/entry out, ack in
//
// Register map: 0 ENTRY_DATA, 1 CMP_DATA, 2 CMP_DMASK, 3 RD_CMD, 4 WR_CMD,
// 5 STATUS (bit0 busy, bits[31:16] timeout count), 6/7 read as zero.
//
// Optional: define CAM_LUT_REG_CTRL_TIMEOUT_EN to abandon a table access
// after TIMEOUT_CYCLES without an ack; the host then sees 0xDEAD_0000.
module cam_lut_reg_ctrl #(
    parameter int CMP_WIDTH      = 32,
    parameter int DATA_WIDTH     = 3,
    parameter int LUT_DEPTH      = 16,
    parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_reg_req,
    input  logic                      i_reg_rd_wr_L,
    input  logic [2:0]                i_reg_addr,
    input  logic [31:0]               i_reg_wr_data,
    output logic                      o_reg_ack,
    output logic [31:0]               o_reg_rd_data,
    output logic [LUT_DEPTH_BITS-1:0] o_tbl_rd_addr,
    output logic                      o_tbl_rd_req,
    input  logic [DATA_WIDTH-1:0]     i_tbl_rd_data,
    input  logic [CMP_WIDTH-1:0]      i_tbl_rd_cmp_data,
    input  logic [CMP_WIDTH-1:0]      i_tbl_rd_cmp_dmask,
    input  logic                      i_tbl_rd_ack,
    output logic [LUT_DEPTH_BITS-1:0] o_tbl_wr_addr,
    output logic                      o_tbl_wr_req,
    output logic [DATA_WIDTH-1:0]     o_tbl_wr_data,
    output logic [CMP_WIDTH-1:0]      o_tbl_wr_cmp_data,
    output logic [CMP_WIDTH-1:0]      o_tbl_wr_cmp_dmask,
    input  logic                      i_tbl_wr_ack
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t                    r_state, w_next;
    logic [DATA_WIDTH-1:0]     r_entry;
    logic [CMP_WIDTH-1:0]      r_cmp, r_mask;
    logic [LUT_DEPTH_BITS-1:0] r_rd_addr, r_wr_addr;
    logic                      r_ack;
    logic [31:0]               r_rd_data;
    logic                      w_ack, w_timeout, w_tmo, w_rd_hit, w_wr_hit, w_stage_wr;
    logic [31:0]               w_rd_data, w_rd_mux;
    logic [15:0]               w_tmo_cnt;

    // Acks only count in the matching wait state; strays elsewhere are dropped.
    assign w_rd_hit   = (r_state == RD_WAIT) && i_tbl_rd_ack;
    assign w_wr_hit   = (r_state == WR_WAIT) && i_tbl_wr_ack;
    assign w_stage_wr = (r_state == IDLE) && i_reg_req && !i_reg_rd_wr_L;

`ifdef CAM_LUT_REG_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait;
    logic [15:0]   r_tmo_cnt;
    logic          r_tmo;
    logic          w_waiting;

    assign w_waiting = (r_state == RD_WAIT) || (r_state == WR_WAIT);
    // An ack in the final wait cycle wins over the timeout.
    assign w_timeout = w_waiting && (r_wait == TW'(TIMEOUT_CYCLES - 1)) && !w_rd_hit && !w_wr_hit;
    assign w_tmo     = r_tmo;
    assign w_tmo_cnt = r_tmo_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wait    <= '0;
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else begin
            r_wait <= w_waiting ? r_wait + 1'b1 : '0;
            if (w_timeout) begin
                r_tmo     <= 1'b1;
                r_tmo_cnt <= (r_tmo_cnt == 16'hFFFF) ? r_tmo_cnt : r_tmo_cnt + 16'd1;
            end else if (r_state == DONE) begin
                r_tmo <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_tmo     = 1'b0;
    // No counter in this build; the parameter is kept so both builds share a port/parameter list.
    assign w_tmo_cnt = 16'(TIMEOUT_CYCLES * 0);
`endif

    always_comb begin
        w_rd_mux = '0;
        case (i_reg_addr)
            3'd0:    w_rd_mux = 32'(r_entry);
            3'd1:    w_rd_mux = 32'(r_cmp);
            3'd2:    w_rd_mux = 32'(r_mask);
            3'd3:    w_rd_mux = 32'(r_rd_addr);
            3'd4:    w_rd_mux = 32'(r_wr_addr);
            3'd5:    w_rd_mux = {w_tmo_cnt, 16'h0000};
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_ack     = 1'b0;
        w_rd_data = '0;
        case (r_state)
            IDLE: if (i_reg_req) begin
                if (!i_reg_rd_wr_L && i_reg_addr == 3'd3)      w_next = RD_WAIT;
                else if (!i_reg_rd_wr_L && i_reg_addr == 3'd4) w_next = WR_WAIT;
                else begin
                    w_ack     = 1'b1;
                    w_rd_data = i_reg_rd_wr_L ? w_rd_mux : '0;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (w_rd_hit || w_wr_hit || w_timeout) w_next = DONE;
                // Busy response: reads see 1 (the busy bit), writes are dropped.
                w_ack     = i_reg_req;
                w_rd_data = {31'd0, i_reg_req && i_reg_rd_wr_L};
            end
            DONE: begin
                w_next    = IDLE;
                w_ack     = 1'b1;
                w_rd_data = w_tmo ? 32'hDEAD_0000 : 32'h0;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_entry   <= '0;
            r_cmp     <= '0;
            r_mask    <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_ack     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_ack     <= w_ack;
            r_rd_data <= w_rd_data;
            if (w_stage_wr) begin
                case (i_reg_addr)
                    3'd0:    r_entry   <= i_reg_wr_data[DATA_WIDTH-1:0];
                    3'd1:    r_cmp     <= i_reg_wr_data[CMP_WIDTH-1:0];
                    3'd2:    r_mask    <= i_reg_wr_data[CMP_WIDTH-1:0];
                    3'd3:    r_rd_addr <= i_reg_wr_data[LUT_DEPTH_BITS-1:0];
                    3'd4:    r_wr_addr <= i_reg_wr_data[LUT_DEPTH_BITS-1:0];
                    default: ;
                endcase
            end
            if (w_rd_hit) begin
                r_entry <= i_tbl_rd_data;
                r_cmp   <= i_tbl_rd_cmp_data;
                r_mask  <= i_tbl_rd_cmp_dmask;
            end
        end
    end

    // Requests decode straight from the state so they fall the instant reset hits.
    assign o_tbl_rd_req       = (r_state == RD_WAIT);
    assign o_tbl_wr_req       = (r_state == WR_WAIT);
    assign o_tbl_rd_addr      = r_rd_addr;
    assign o_tbl_wr_addr      = r_wr_addr;
    assign o_tbl_wr_data      = r_entry;
    assign o_tbl_wr_cmp_data  = r_cmp;
    assign o_tbl_wr_cmp_dmask = r_mask;
    assign o_reg_ack          = r_ack;
    assign o_reg_rd_data      = r_rd_data;
endmodule

// File: tb/tb_cam_lut_reg_ctrl.sv
// tb_cam_lut_reg_ctrl: self-checking bench for cam_lut_reg_ctrl using a register-level model.
module tb_cam_lut_reg_ctrl;
    localparam int DW = 3;
    localparam int CW = 32;
    localparam int AB = 4;
    localparam int TO = 8;

    logic          clk = 1'b0, rst = 1'b1;
    logic          reg_req = 1'b0, reg_rw = 1'b0;
    logic [2:0]    reg_addr = '0;
    logic [31:0]   reg_wdata = '0;
    logic          reg_ack;
    logic [31:0]   reg_rdata;
    logic [AB-1:0] rd_addr, wr_addr;
    logic          rd_req, wr_req;
    logic [DW-1:0] rd_data = '0;
    logic [CW-1:0] rd_cmp = '0, rd_mask = '0;
    logic          rd_ack = 1'b0, wr_ack = 1'b0;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] wr_cmp, wr_mask;

    int pass_cnt = 0, total = 0, cyc = 0;
    logic [31:0] m_reg [0:4];
    int          m_tmo = 0;

    cam_lut_reg_ctrl #(.CMP_WIDTH(CW), .DATA_WIDTH(DW), .LUT_DEPTH(16), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(rst), .i_reg_req(reg_req), .i_reg_rd_wr_L(reg_rw),
        .i_reg_addr(reg_addr), .i_reg_wr_data(reg_wdata), .o_reg_ack(reg_ack), .o_reg_rd_data(reg_rdata),
        .o_tbl_rd_addr(rd_addr), .o_tbl_rd_req(rd_req), .i_tbl_rd_data(rd_data),
        .i_tbl_rd_cmp_data(rd_cmp), .i_tbl_rd_cmp_dmask(rd_mask), .i_tbl_rd_ack(rd_ack),
        .o_tbl_wr_addr(wr_addr), .o_tbl_wr_req(wr_req), .o_tbl_wr_data(wr_data),
        .o_tbl_wr_cmp_data(wr_cmp), .o_tbl_wr_cmp_dmask(wr_mask), .i_tbl_wr_ack(wr_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int field_bits(input int a);
        return (a == 0) ? DW : (a <= 2) ? CW : AB;
    endfunction

    function automatic logic [31:0] keep_low(input logic [31:0] d, input int bits);
        longint unsigned lim;
        lim = 64'd1 << bits;
        return 32'(longint'(d) % lim);
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        if (a <= 4) return m_reg[a];
        if (a == 5) return 32'(m_tmo) << 16;
        return 32'h0;
    endfunction

    task automatic model_write(input int a, input logic [31:0] d);
        if (a <= 4) m_reg[a] = keep_low(d, field_bits(a));
    endtask

    task automatic model_clear();
        for (int i = 0; i <= 4; i++) m_reg[i] = '0;
        m_tmo = 0;
    endtask

    // Single host access; returns read data, latency in cycles, and the cycle the ack was seen.
    task automatic access(input logic rd, input logic [2:0] a, input logic [31:0] d,
                          output logic [31:0] q, output int lat, output int hc);
        @(negedge clk);
        reg_req = 1'b1; reg_rw = rd; reg_addr = a; reg_wdata = d;
        lat = -1; hc = -1; q = 'x;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) reg_req = 1'b0;
            if (reg_ack) begin q = reg_rdata; lat = n; hc = cyc; break; end
        end
    endtask

    // Table-side responder: waits for the request, acks dly cycles later for one cycle.
    task automatic respond(input logic rd, input int dly, input logic [DW-1:0] d,
                           input logic [CW-1:0] c, input logic [CW-1:0] m, output int acyc);
        logic seen;
        seen = 1'b0; acyc = -1;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = rd ? rd_req : wr_req;
        end
        total++;
        if (!seen) $display("FAIL respond_req: request got %0b want 1", seen);
        else pass_cnt++;
        repeat (dly) @(negedge clk);
        if (rd) begin rd_ack = 1'b1; rd_data = d; rd_cmp = c; rd_mask = m; end
        else wr_ack = 1'b1;
        acyc = cyc;
        @(negedge clk);
        rd_ack = 1'b0; wr_ack = 1'b0;
        total++;
        if ((rd ? rd_req : wr_req) !== 1'b0) $display("FAIL req_drop: req %0b want 0", rd ? rd_req : wr_req);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [31:0] q; int lat, hc;
        #1;
        total++;
        if ({reg_ack, reg_rdata, rd_req, wr_req, rd_addr, wr_addr, wr_data, wr_cmp, wr_mask} !== '0)
            $display("FAIL reset_outputs: ack=%0b rd=%h rdreq=%0b wrreq=%0b want all 0", reg_ack, reg_rdata, rd_req, wr_req);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            access(1'b1, 3'(a), 32'h0, q, lat, hc);
            total++;
            if (q !== 32'h0 || lat != 1) $display("FAIL reset_read%0d: data=%h lat=%0d want 0 lat 1", a, q, lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_staging();
        logic [31:0] q, d; int lat, hc, a;
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(7); d = $urandom;
            if ($urandom_range(1) == 1) begin
                if (a == 3 || a == 4) a = $urandom_range(2);
                access(1'b0, 3'(a), d, q, lat, hc);
                model_write(a, d);
                total++;
                if (lat != 1) $display("FAIL stage_wr_lat: addr %0d lat=%0d want 1", a, lat);
                else pass_cnt++;
            end else begin
                access(1'b1, 3'(a), 32'h0, q, lat, hc);
                total++;
                if (q !== exp_read(a) || lat != 1)
                    $display("FAIL stage_rd: addr %0d data=%h lat=%0d want %h lat 1", a, q, lat, exp_read(a));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_write_cmd();
        logic [31:0] q; int lat, hc, acyc;
        access(1'b0, 3'd0, 32'd5, q, lat, hc);          model_write(0, 32'd5);
        access(1'b0, 3'd1, 32'h0A000001, q, lat, hc);   model_write(1, 32'h0A000001);
        access(1'b0, 3'd2, 32'hFF, q, lat, hc);         model_write(2, 32'hFF);
        fork
            access(1'b0, 3'd4, 32'd3, q, lat, hc);
            respond(1'b0, 1, '0, '0, '0, acyc);
        join
        model_write(4, 32'd3);
        total++;
        if (wr_addr !== 4'd3 || wr_data !== 3'd5 || wr_cmp !== 32'h0A000001 || wr_mask !== 32'hFF)
            $display("FAIL wr_fields: addr=%0d data=%0d cmp=%h mask=%h want 3 5 0a000001 ff", wr_addr, wr_data, wr_cmp, wr_mask);
        else pass_cnt++;
        total++;
        if (hc - acyc != 2 || acyc < 0) $display("FAIL wr_latency: ack-to-reg_ack %0d cycles want 2", hc - acyc);
        else pass_cnt++;
        access(1'b1, 3'd4, 32'h0, q, lat, hc);
        total++;
        if (q !== 32'd3) $display("FAIL wr_addr_read: got %h want 3", q);
        else pass_cnt++;
    endtask

    task automatic test_read_cmd();
        logic [31:0] q, c, m; logic [DW-1:0] d; logic [AB-1:0] ad; int lat, hc, acyc, dly;
        for (int i = 0; i < 5; i++) begin
            ad  = (i == 0) ? 4'd3 : 4'($urandom);
            d   = (i == 0) ? 3'd2 : 3'($urandom);
            c   = (i == 0) ? 32'hC0A80001 : $urandom;
            m   = (i == 0) ? 32'h0 : $urandom;
            dly = (i == 0) ? 2 : $urandom_range(1, 5);
            fork
                access(1'b0, 3'd3, 32'(ad), q, lat, hc);
                respond(1'b1, dly, d, c, m, acyc);
            join
            total++;
            if (hc - acyc != 2 || acyc < 0 || q !== 32'h0)
                $display("FAIL rd_cmd_done: latency %0d data %h want 2 and 0", hc - acyc, q);
            else pass_cnt++;
            model_write(3, 32'(ad)); model_write(0, 32'(d)); model_write(1, c); model_write(2, m);
            for (int a = 0; a < 4; a++) begin
                access(1'b1, 3'(a), 32'h0, q, lat, hc);
                total++;
                if (q !== exp_read(a)) $display("FAIL rd_capture: addr %0d got %h want %h", a, q, exp_read(a));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q; logic [DW-1:0] d1; logic [31:0] c1; int acks, lat, hc;
        d1 = 3'($urandom); c1 = $urandom; acks = 0;
        @(negedge clk); reg_req = 1'b1; reg_rw = 1'b0; reg_addr = 3'd3; reg_wdata = 32'd9;
        @(negedge clk); reg_req = 1'b0; rd_ack = 1'b1; rd_data = d1; rd_cmp = c1; rd_mask = ~c1;
        acks += int'(reg_ack);
        @(negedge clk); rd_data = ~d1; rd_cmp = ~c1; rd_mask = c1;
        acks += int'(reg_ack);
        @(negedge clk); rd_ack = 1'b0;
        for (int n = 0; n < 7; n++) begin acks += int'(reg_ack); @(negedge clk); end
        total++;
        if (acks != 1) $display("FAIL double_ack_count: reg_ack pulses %0d want 1", acks);
        else pass_cnt++;
        model_write(3, 32'd9); model_write(0, 32'(d1)); model_write(1, c1); model_write(2, ~c1);
        for (int a = 0; a < 3; a++) begin
            access(1'b1, 3'(a), 32'h0, q, lat, hc);
            total++;
            if (q !== exp_read(a)) $display("FAIL double_ack_data: addr %0d got %h want %h", a, q, exp_read(a));
            else pass_cnt++;
        end
    endtask

    task automatic test_stray_ack();
        logic [31:0] q; int lat, hc;
        @(negedge clk); rd_ack = 1'b1; wr_ack = 1'b1; rd_data = ~m_reg[0][DW-1:0]; rd_cmp = ~m_reg[1]; rd_mask = ~m_reg[2];
        @(negedge clk);
        @(negedge clk); rd_ack = 1'b0; wr_ack = 1'b0;
        total++;
        if (reg_ack !== 1'b0 || rd_req !== 1'b0 || wr_req !== 1'b0)
            $display("FAIL stray_idle: ack=%0b rdreq=%0b wrreq=%0b want 0", reg_ack, rd_req, wr_req);
        else pass_cnt++;
        @(negedge clk); reg_req = 1'b1; reg_rw = 1'b0; reg_addr = 3'd4; reg_wdata = 32'd7;
        @(negedge clk); reg_req = 1'b0; rd_ack = 1'b1;
        total++;
        if (wr_req !== 1'b1) $display("FAIL stray_wait_req: wr_req %0b want 1", wr_req);
        else pass_cnt++;
        @(negedge clk); rd_ack = 1'b0; wr_ack = 1'b1;
        total++;
        if (wr_req !== 1'b1 || reg_ack !== 1'b0) $display("FAIL stray_opposite: wr_req %0b ack %0b want 1 0", wr_req, reg_ack);
        else pass_cnt++;
        @(negedge clk); wr_ack = 1'b0;
        @(negedge clk);
        total++;
        if (reg_ack !== 1'b1) $display("FAIL stray_complete: reg_ack %0b want 1", reg_ack);
        else pass_cnt++;
        model_write(4, 32'd7);
        for (int a = 0; a < 5; a++) begin
            access(1'b1, 3'(a), 32'h0, q, lat, hc);
            total++;
            if (q !== exp_read(a)) $display("FAIL stray_data: addr %0d got %h want %h", a, q, exp_read(a));
            else pass_cnt++;
        end
    endtask

    task automatic test_busy();
        logic [31:0] q, c; logic [DW-1:0] d; int lat, hc;
        d = 3'($urandom); c = $urandom;
        @(negedge clk); reg_req = 1'b1; reg_rw = 1'b0; reg_addr = 3'd3; reg_wdata = 32'd12;
        @(negedge clk); reg_rw = 1'b1; reg_addr = 3'd5;
        total++;
        if (rd_req !== 1'b1 || rd_addr !== 4'd12) $display("FAIL busy_req: rd_req %0b addr %0d want 1 12", rd_req, rd_addr);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (reg_ack !== 1'b1 || reg_rdata !== 32'h1 || rd_req !== 1'b1)
            $display("FAIL busy_status: ack %0b data %h rd_req %0b want 1 00000001 1", reg_ack, reg_rdata, rd_req);
        else pass_cnt++;
        reg_rw = 1'b0; reg_addr = 3'd0; reg_wdata = 32'h7;
        @(negedge clk);
        total++;
        if (reg_ack !== 1'b1 || rd_req !== 1'b1) $display("FAIL busy_write: ack %0b rd_req %0b want 1 1", reg_ack, rd_req);
        else pass_cnt++;
        reg_rw = 1'b1; rd_ack = 1'b1; rd_data = d; rd_cmp = c; rd_mask = 32'h0;
        @(negedge clk); reg_req = 1'b0; rd_ack = 1'b0;
        total++;
        if (reg_ack !== 1'b1 || reg_rdata !== 32'h1 || rd_req !== 1'b0)
            $display("FAIL busy_with_ack: ack %0b data %h rd_req %0b want 1 00000001 0", reg_ack, reg_rdata, rd_req);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (reg_ack !== 1'b1 || reg_rdata !== 32'h0) $display("FAIL busy_done: ack %0b data %h want 1 0", reg_ack, reg_rdata);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (reg_ack !== 1'b0) $display("FAIL busy_single_ack: ack %0b want 0", reg_ack);
        else pass_cnt++;
        model_write(3, 32'd12); model_write(0, 32'(d)); model_write(1, c); model_write(2, 32'h0);
        for (int a = 0; a < 3; a++) begin
            access(1'b1, 3'(a), 32'h0, q, lat, hc);
            total++;
            if (q !== exp_read(a)) $display("FAIL busy_data: addr %0d got %h want %h", a, q, exp_read(a));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q; int lat, hc, acks;
        acks = 0;
        @(negedge clk); reg_req = 1'b1; reg_rw = 1'b0; reg_addr = 3'd4; reg_wdata = 32'd9;
        @(negedge clk); reg_req = 1'b0;
        total++;
        if (wr_req !== 1'b1) $display("FAIL mid_req: wr_req %0b want 1", wr_req);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({wr_req, rd_req, reg_ack, wr_addr, rd_addr, wr_data, wr_cmp, wr_mask} !== '0)
            $display("FAIL mid_reset: wr_req %0b addr %0d data %0d cmp %h want all 0", wr_req, wr_addr, wr_data, wr_cmp);
        else pass_cnt++;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 6; n++) begin @(negedge clk); acks += int'(reg_ack); end
        total++;
        if (acks != 0) $display("FAIL mid_no_ack: reg_ack pulses %0d want 0", acks);
        else pass_cnt++;
        model_clear();
        for (int a = 0; a < 8; a++) begin
            access(1'b1, 3'(a), 32'h0, q, lat, hc);
            total++;
            if (q !== 32'h0) $display("FAIL mid_read: addr %0d got %h want 0", a, q);
            else pass_cnt++;
        end
    endtask

`ifdef CAM_LUT_REG_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] q; int lat, hc;
        access(1'b0, 3'd3, 32'd6, q, lat, hc);
        total++;
        if (q !== 32'hDEAD_0000 || lat != TO + 2 || rd_req !== 1'b0)
            $display("FAIL timeout: data %h lat %0d rd_req %0b want dead0000 %0d 0", q, lat, rd_req, TO + 2);
        else pass_cnt++;
        m_tmo++;
        model_write(3, 32'd6);
        for (int a = 0; a < 6; a++) begin
            access(1'b1, 3'(a), 32'h0, q, lat, hc);
            total++;
            if (q !== exp_read(a)) $display("FAIL timeout_regs: addr %0d got %h want %h", a, q, exp_read(a));
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_staging();
        test_write_cmd();
        test_read_cmd();
        test_back_to_back();
        test_stray_ack();
        test_busy();
`ifdef CAM_LUT_REG_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/cam_lut_reg_ctrl.md
Name: cam_lut_reg_ctrl

Overview:
- Register-side initiator for a CAM/LUT table.
- Converts single-beat host register accesses into the table's rd_req/rd_ack and wr_req/wr_ack handshakes.
- Holds staging registers for entry data, compare data and don't-care mask, and captures read-back results.
- Sits between the host register bus and the CAM lookup-table controller in the output-port-lookup stage.

Parameters:
- CMP_WIDTH, 32: compare/mask width; legal range 1..32.
- DATA_WIDTH, 3: LUT data width; legal range 1..32.
- LUT_DEPTH, 16: table entries.
- LUT_DEPTH_BITS, log2(LUT_DEPTH): table address width.
- TIMEOUT_CYCLES, 64: maximum wait for a table ack; only used when CAM_LUT_REG_CTRL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- reg_req  in  1  host access strobe, one-cycle pulse
- reg_rd_wr_L  in  1  1=read, 0=write
- reg_addr  in  3  word offset
- reg_wr_data  in  32  host write data
- reg_ack  out  1  one-cycle completion pulse
- reg_rd_data  out  32  host read data, valid with reg_ack
- tbl_rd_addr  out  LUT_DEPTH_BITS  table read address
- tbl_rd_req  out  1  table read request
- tbl_rd_data  in  DATA_WIDTH  entry data from the table
- tbl_rd_cmp_data  in  CMP_WIDTH  entry compare data from the table
- tbl_rd_cmp_dmask  in  CMP_WIDTH  entry don't-care mask from the table
- tbl_rd_ack  in  1  read-complete pulse
- tbl_wr_addr  out  LUT_DEPTH_BITS  table write address
- tbl_wr_req  out  1  table write request
- tbl_wr_data  out  DATA_WIDTH  entry data to write
- tbl_wr_cmp_data  out  CMP_WIDTH  compare data to write
- tbl_wr_cmp_dmask  out  CMP_WIDTH  don't-care mask to write
- tbl_wr_ack  in  1  write-complete pulse

Behaviour:
- Register map (offset, name, access):
  - 0 ENTRY_DATA, RW
  - 1 CMP_DATA, RW
  - 2 CMP_DMASK, RW
  - 3 RD_CMD, W: writes the address and starts a table read; a read of offset 3 returns the last read address.
  - 4 WR_CMD, W: writes the address and starts a table write; a read of offset 4 returns the last write address.
  - 5 STATUS, R: bit0 = busy; bits[31:16] = timeout count.
  - 6, 7: reads return 0, writes are ignored.
- Field widths: only the low DATA_WIDTH/CMP_WIDTH/LUT_DEPTH_BITS bits of a staging register are stored; upper bits read 0.
- Staging registers drive tbl_wr_* directly.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - Any non-command access gets reg_ack on the cycle after reg_req.
  - Write to RD_CMD: latch tbl_rd_addr, assert tbl_rd_req, go to RD_WAIT.
  - Write to WR_CMD: latch tbl_wr_addr, assert tbl_wr_req, go to WR_WAIT.
- RD_WAIT:
  - tbl_rd_req is held high until tbl_rd_ack, then dropped in the next cycle.
  - On tbl_rd_ack, capture tbl_rd_data/tbl_rd_cmp_data/tbl_rd_cmp_dmask into ENTRY_DATA/CMP_DATA/CMP_DMASK; go to DONE.
- WR_WAIT: tbl_wr_req is held high until tbl_wr_ack, then dropped; go to DONE.
- DONE: pulse reg_ack for 1 cycle with reg_rd_data=0; return to IDLE.
- Host-visible latency: a command completes 2 cycles after the table ack is sampled.
- Stray acks: extra tbl_rd_ack/tbl_wr_ack pulses arriving in IDLE, DONE or the opposite wait state are ignored. They do not update staging registers.
- Host access while busy: any reg_req outside IDLE, including a STATUS read, is acked the next cycle with reg_rd_data = 0x0000_0001 for reads and no effect for writes. Commands are never queued.
- Simultaneous ack and reg_req in a wait state: the ack is processed; the reg_req gets the busy response.
- Reset values (asynchronous, immediate, including mid-handshake):
  - All outputs 0.
  - Staging registers 0, timeout count 0, state IDLE.
  - tbl_rd_req/tbl_wr_req drop the instant reset asserts.
- reg_ack is never high for two consecutive cycles for a single reg_req.

Optional Feature:
- Macro: CAM_LUT_REG_CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter resets on entry to RD_WAIT/WR_WAIT.
  - On reaching TIMEOUT_CYCLES with no ack: drop the request and go to DONE; reg_ack carries reg_rd_data = 0xDEAD_0000.
  - Staging registers are unchanged.
  - The STATUS timeout count increments, saturating at 0xFFFF.
- Not defined: no counter logic; wait states are unbounded; STATUS[31:16] reads 0.

Test Plan:
- Write 5 to ENTRY_DATA, 0x0A000001 to CMP_DATA, 0xFF to CMP_DMASK, then 3 to WR_CMD; responder acks 1 cycle after tbl_wr_req. Required: tbl_wr_addr=3, tbl_wr_data=5, tbl_wr_cmp_data=0x0A000001, tbl_wr_cmp_dmask=0xFF; tbl_wr_req drops after the ack; reg_ack follows 2 cycles later.
- Write 3 to RD_CMD; responder returns data=2, cmp=0xC0A80001, mask=0 with tbl_rd_ack 2 cycles later. Required: ENTRY_DATA reads 2, CMP_DATA reads 0xC0A80001, CMP_DMASK reads 0.
- Responder issues 2 back-to-back tbl_rd_ack pulses. Required: only one reg_ack; the second ack does not alter staging registers.
- STATUS read during RD_WAIT. Required: next-cycle reg_ack with data 0x00000001; tbl_rd_req stays high.
- Assert reset mid-WR_WAIT. Required: tbl_wr_req=0 immediately; no reg_ack after release; all registers read 0.
- With CAM_LUT_REG_CTRL_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, issue RD_CMD and never ack. Required: reg_ack with 0xDEAD_0000; STATUS reads 0x00010000.
